// File: rtl/trace_uart_if.sv
`default_nettype none
// -----------------------------------------------------------------------------
// trace_uart_if: CPU trace inputs and UART/status outputs of trace_uart
// Rev 1.0
// -----------------------------------------------------------------------------
interface trace_uart_if #(
  parameter int PC_WIDTH       = 8,
  parameter int REGISTER_WIDTH = 8
);
  logic [PC_WIDTH-1:0]       pc;
  logic [REGISTER_WIDTH-1:0] register1Value;
  logic                      enable;
  logic                      txd;
  logic                      busy;
  logic                      overflow;

  modport master (
    output pc, register1Value, enable,
    input  txd, busy, overflow
  );

  modport slave (
    input  pc, register1Value, enable,
    output txd, busy, overflow
  );
endinterface
`default_nettype wire

// File: rtl/trace_uart.sv
`default_nettype none
// -----------------------------------------------------------------------------
// trace_uart: sends "PP:RR\r\n" on an 8N1 UART whenever register1Value changes
// Rev 1.0
// -----------------------------------------------------------------------------
module trace_uart #(
  parameter int PC_WIDTH       = 8,
  parameter int REGISTER_WIDTH = 8,
  parameter int CLOCKS_PER_BIT = 104
) (
  input  logic        clock,
  input  logic        isResetN,
  trace_uart_if.slave bus
);
  localparam int NP     = PC_WIDTH / 4;
  localparam int NR     = REGISTER_WIDTH / 4;
  localparam int NCHARS = NP + NR + 3;
  localparam int CW     = $clog2(NCHARS);
  localparam int TW     = (CLOCKS_PER_BIT > 2) ? $clog2(CLOCKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST_CHAR = CW'(NCHARS - 1);
  localparam logic [TW-1:0] LAST_TICK = TW'(CLOCKS_PER_BIT - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  state_t                    r_state;
  logic [TW-1:0]             r_timer;
  logic [2:0]                r_bit_idx;
  logic [CW-1:0]             r_char_idx;
  logic                      r_hold;
  logic [PC_WIDTH-1:0]       r_frame_pc;
  logic [REGISTER_WIDTH-1:0] r_frame_reg;
  logic [PC_WIDTH-1:0]       r_pend_pc;
  logic [REGISTER_WIDTH-1:0] r_pend_reg;
  logic                      r_pend_valid;
  logic [REGISTER_WIDTH-1:0] r_last;
  logic                      r_first;
  logic                      r_txd;
  logic                      r_busy;
  logic                      r_overflow;

  logic       w_change;
  logic       w_direct;
  logic       w_take;
  logic       w_tick;
  logic [3:0] w_nib;
  logic [7:0] w_char;

  function automatic logic [7:0] f_hex(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
  endfunction

  assign w_change = bus.enable & (r_first | (bus.register1Value != r_last));
  assign w_direct = (r_state == S_IDLE) && !r_pend_valid;
  assign w_tick   = (r_timer == LAST_TICK);
  // Pending is consumed either at the end of the last stop bit or from IDLE.
  assign w_take   = r_pend_valid &&
                    ((r_state == S_IDLE) ||
                     (r_state == S_STOP && w_tick && r_char_idx == LAST_CHAR));

  always_comb begin
    w_nib  = 4'h0;
    w_char = 8'h0A;
    if (r_char_idx < CW'(NP)) begin
      w_nib  = 4'(r_frame_pc >> (4 * (NP - 1 - int'(r_char_idx))));
      w_char = f_hex(w_nib);
    end else if (r_char_idx == CW'(NP)) begin
      w_char = 8'h3A;
    end else if (r_char_idx < CW'(NP + NR + 1)) begin
      w_nib  = 4'(r_frame_reg >> (4 * (NP + NR - int'(r_char_idx))));
      w_char = f_hex(w_nib);
    end else if (r_char_idx == CW'(NP + NR + 1)) begin
      w_char = 8'h0D;
    end
  end

  always_ff @(posedge clock or negedge isResetN) begin
    if (!isResetN) begin
      r_state      <= S_IDLE;
      r_timer      <= '0;
      r_bit_idx    <= '0;
      r_char_idx   <= '0;
      r_hold       <= 1'b0;
      r_frame_pc   <= '0;
      r_frame_reg  <= '0;
      r_pend_pc    <= '0;
      r_pend_reg   <= '0;
      r_pend_valid <= 1'b0;
      r_last       <= '0;
      r_first      <= 1'b1;
      r_txd        <= 1'b1;
      r_busy       <= 1'b0;
      r_overflow   <= 1'b0;
    end else begin
      if (w_change) begin
        r_last  <= bus.register1Value;
        r_first <= 1'b0;
      end

      case (r_state)
        S_IDLE: begin
          if (r_pend_valid || w_change) begin
            r_frame_pc   <= r_pend_valid ? r_pend_pc  : bus.pc;
            r_frame_reg  <= r_pend_valid ? r_pend_reg : bus.register1Value;
            r_pend_valid <= 1'b0;
            r_state      <= S_START;
            r_timer      <= '0;
            r_char_idx   <= '0;
            r_hold       <= 1'b0;
            r_txd        <= 1'b0;
            r_busy       <= 1'b1;
          end
        end
        S_START: begin
          if (r_hold) begin
            r_hold <= 1'b0;
            r_txd  <= 1'b0;
          end else if (w_tick) begin
            r_timer   <= '0;
            r_bit_idx <= '0;
            r_state   <= S_DATA;
            r_txd     <= w_char[0];
          end else begin
            r_timer <= r_timer + TW'(1);
          end
        end
        S_DATA: begin
          if (w_tick) begin
            r_timer <= '0;
            if (r_bit_idx == 3'd7) begin
              r_state <= S_STOP;
              r_txd   <= 1'b1;
            end else begin
              r_bit_idx <= r_bit_idx + 3'd1;
              r_txd     <= w_char[r_bit_idx + 3'd1];
            end
          end else begin
            r_timer <= r_timer + TW'(1);
          end
        end
        S_STOP: begin
          if (w_tick) begin
            r_timer <= '0;
            if (r_char_idx != LAST_CHAR) begin
              r_char_idx <= r_char_idx + CW'(1);
              r_state    <= S_START;
              r_txd      <= 1'b0;
            end else if (r_pend_valid) begin
              // Back-to-back frame: txd idles high for one cycle before START.
              r_frame_pc   <= r_pend_pc;
              r_frame_reg  <= r_pend_reg;
              r_pend_valid <= 1'b0;
              r_char_idx   <= '0;
              r_state      <= S_START;
              r_hold       <= 1'b1;
            end else begin
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
            end
          end else begin
            r_timer <= r_timer + TW'(1);
          end
        end
        default: r_state <= S_IDLE;
      endcase

      if (w_change && !w_direct) begin
        r_pend_pc    <= bus.pc;
        r_pend_reg   <= bus.register1Value;
        r_pend_valid <= 1'b1;
        if (r_pend_valid && !w_take) r_overflow <= 1'b1;
      end
    end
  end

  assign bus.txd      = r_txd;
  assign bus.busy     = r_busy;
  assign bus.overflow = r_overflow;
endmodule
`default_nettype wire

// File: doc/trace_uart.md
Name: trace_uart

Overview:
- Debug trace stage directly downstream of the CPU core.
- Consumes the core's `pc` and `register1Value` outputs. Whenever `register1Value` changes, it serialises one ASCII hex line `PP:RR\r\n` on a UART TX pin.
- Replaces simulation-only register monitors on hardware; the board has no other readback path.

Parameters:
- PC_WIDTH, 8, width of `pc`. Multiple of 4, range 4..16.
- REGISTER_WIDTH, 8, width of `register1Value`. Multiple of 4, range 4..16.
- CLOCKS_PER_BIT, 104, clock cycles per UART bit. Must be ≥2.

Ports:
- clock  in  1  system clock, rising edge.
- isResetN  in  1  asynchronous, active-low reset.
- pc  in  PC_WIDTH  current program counter from the CPU.
- register1Value  in  REGISTER_WIDTH  traced register value from the CPU.
- enable  in  1  when high, changes are captured.
- txd  out  1  UART serial out, 8N1, LSB first, idle high.
- busy  out  1  high while a frame is being transmitted.
- overflow  out  1  sticky; set when a pending capture is overwritten.

Behaviour:
- Reset (async, isResetN=0):
  - Outputs: txd=1, busy=0, overflow=0.
  - State → IDLE; pending buffer empty; bit timer and character index cleared.
  - `firstFlag` set, so the first enabled cycle always captures.
- Change detect, evaluated each cycle:
  - `change = enable & (firstFlag | register1Value != lastValue)`.
  - On change: `lastValue <= register1Value`, `firstFlag <= 0`, and `{pc, register1Value}` is latched.
  - With enable=0: nothing is captured and lastValue is held. On re-enable, a differing value is captured.
- Capture destination:
  - IDLE and pending empty → frame buffer; state → START next cycle.
  - Otherwise → pending buffer. If pending was already full, it is overwritten and overflow is set to 1.
- Leaving STOP of the last character:
  - If pending is full: pending moves to the frame buffer, pending is emptied, state → START; txd stays high for exactly one cycle.
  - Else state → IDLE.
  - A change in that same cycle goes into pending.
- Frame content:
  - PC_WIDTH/4 hex digits of pc, MS nibble first.
  - 0x3A (`:`).
  - REGISTER_WIDTH/4 hex digits of the value.
  - 0x0D, 0x0A.
  - Digit encoding: 0–9 → 0x30–0x39, A–F → 0x41–0x46 (uppercase).
  - At defaults a frame is 7 characters.
- State machine (per character), each state lasting CLOCKS_PER_BIT cycles counted by the bit timer:
  - START: txd=0.
  - DATA: 8 bits, LSB first, bit index 0..7.
  - STOP: txd=1.
  - After STOP: if the character index < last, increment it and → START (no idle gap between characters); else apply the pending rule above.
- Timing:
  - Frame length = 10·CLOCKS_PER_BIT·chars cycles.
  - Latency: txd falls on the cycle after the capture edge.
  - busy=1 from that cycle through the final stop-bit cycle.
- txd is registered (glitch-free). pc and register1Value are sampled only at capture, so later changes do not corrupt a frame in flight.
- overflow clears only on reset.
- Reset mid-frame:
  - txd goes high immediately (asynchronously) and the partial frame is discarded.
  - After release, the next enabled cycle re-captures the current value (firstFlag).

Test Plan:
- Reset with CLOCKS_PER_BIT=4 → txd=1, busy=0, overflow=0 held during reset.
- Release reset, pc=0x00, value=0x00, enable=1 → bytes 0x30 0x30 0x3A 0x30 0x30 0x0D 0x0A.
  - Each bit lasts 4 cycles; busy high for exactly 280 cycles; then busy=0, txd=1.
- From idle with lastValue=0x00, set value=0xA5 at pc=0x1F → frame "1F:A5\r\n" (0x31 0x46 0x3A 0x41 0x35 0x0D 0x0A).
  - Start bit begins 1 cycle after the change; no frame if the value is held afterward.
- During a frame, value goes 0x01 then 0x02 at pc=0x05 → overflow=1.
  - Exactly one extra frame "05:02\r\n" follows, after a single idle-high cycle.
- Assert isResetN=0 in the middle of the 3rd character → txd=1 and busy=0 the same cycle.
  - After release, the full current-value frame is retransmitted.
- With enable=0, toggle the value 0x10→0x20→0x30 → txd stays 1, busy stays 0.
  - Raise enable with value=0x30 → one frame carrying 0x30.
